// File: rtl/color_palette_pkg.sv
`default_nettype none
// ============================================================================
// Module      : color_palette_pkg
// Description : Shared constants and types for the AXI colour palette:
//               AXI response codes, CTRL bit positions, write-FSM states and
//               a WSTRB-to-bitmask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package color_palette_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_COMMIT_REQ_BIT     = 0;
    localparam int CTRL_AUTO_COMMIT_BIT    = 1;
    localparam int CTRL_COMMIT_PENDING_BIT = 2;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_bank.sv
`default_nettype none
// ============================================================================
// Module      : palette_bank
// Description : Double-buffered palette storage. The shadow bank takes
//               byte-masked writes from the bus; on commit the shadow bank is
//               copied into the active bank (except an entry written in the
//               same cycle). The active bank feeds a 1-cycle pixel lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module palette_bank
    import color_palette_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int COLOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_wr_en,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_wr_idx,
    input  logic [COLOR_WIDTH-1:0]         i_wr_data,
    input  logic [3:0]                     i_wr_strb,
    input  logic                           i_commit,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_rd_idx,
    output logic [COLOR_WIDTH-1:0]         o_rd_data,
    input  logic                           i_pix_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_pix_index,
    output logic                           o_pix_color_valid,
    output logic [COLOR_WIDTH-1:0]         o_pix_color
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [COLOR_WIDTH-1:0] shadow_q [NUM_ENTRIES];
    logic [COLOR_WIDTH-1:0] shadow_d [NUM_ENTRIES];
    logic [COLOR_WIDTH-1:0] active_q [NUM_ENTRIES];
    logic [COLOR_WIDTH-1:0] active_d [NUM_ENTRIES];
    logic [COLOR_WIDTH-1:0] pix_color_q;
    logic [COLOR_WIDTH-1:0] pix_color_d;
    logic                   pix_color_valid_q;
    logic                   pix_color_valid_d;
    logic [COLOR_WIDTH-1:0] wr_mask;

    assign wr_mask = COLOR_WIDTH'(strb_to_mask(i_wr_strb));

    // Bus read port sees the shadow bank before any same-cycle write
    assign o_rd_data         = shadow_q[i_rd_idx];
    assign o_pix_color       = pix_color_q;
    assign o_pix_color_valid = pix_color_valid_q;

    // Next-state: shadow write, commit copy (skipping the entry being written), lookup
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i_commit && !(i_wr_en && (i_wr_idx == IDX_W'(i)))) begin
                active_d[i] = shadow_q[i];
            end
        end
        if (i_wr_en) begin
            shadow_d[i_wr_idx] = (shadow_q[i_wr_idx] & ~wr_mask) | (i_wr_data & wr_mask);
        end
        pix_color_d       = active_q[i_pix_index];
        pix_color_valid_d = i_pix_valid;
    end

    // Storage and lookup registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pix_color_q       <= '0;
            pix_color_valid_q <= 1'b0;
        end else begin
            shadow_q          <= shadow_d;
            active_q          <= active_d;
            pix_color_q       <= pix_color_d;
            pix_color_valid_q <= pix_color_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_color_palette.sv
`default_nettype none
// ============================================================================
// Module      : axi_color_palette
// Description : AXI4-Lite slave exposing a double-buffered colour palette.
//               Word i is shadow entry i, word NUM_ENTRIES is CTRL
//               (bit0 commit request W1S, bit1 auto_commit, bit2
//               commit_pending RO). A pending commit is applied on vsync.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_color_palette
    import color_palette_pkg::*;
#(
    parameter int NUM_ENTRIES        = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int COLOR_WIDTH        = 24
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            vsync,
    input  logic                            pix_valid,
    input  logic [$clog2(NUM_ENTRIES)-1:0]  pix_index,
    output logic                            pix_color_valid,
    output logic [COLOR_WIDTH-1:0]          pix_color
);

    localparam int                IDX_W     = $clog2(NUM_ENTRIES);
    localparam int                WORD_W    = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] CTRL_WORD = WORD_W'(NUM_ENTRIES);

    wr_state_e                         wr_state_q, wr_state_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr_q, awaddr_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                              bvalid_q, bvalid_d;
    logic [1:0]                        bresp_q, bresp_d;
    logic                              rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                        rresp_q, rresp_d;
    logic                              auto_commit_q, auto_commit_d;
    logic                              commit_pending_q, commit_pending_d;

    logic                              aw_hs, w_hs, ar_hs;
    logic                              wr_fire;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb;
    logic [WORD_W-1:0]                 wr_word, rd_word;
    logic                              wr_is_pal, wr_is_ctrl, rd_is_pal, rd_is_ctrl;
    logic                              shadow_we, ctrl_we, commit;
    logic [COLOR_WIDTH-1:0]            bank_rd_data;
    logic                              unused_bits;

    // Ready decodes from the write state; held low while reset is asserted
    assign S_AXI_AWREADY = ~ARESET & ((wr_state_q == W_IDLE) | (wr_state_q == W_HAVE_DATA));
    assign S_AXI_WREADY  = ~ARESET & ((wr_state_q == W_IDLE) | (wr_state_q == W_HAVE_ADDR));
    assign S_AXI_ARREADY = ~ARESET & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    assign wr_word    = wr_addr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_is_pal  = (wr_word < CTRL_WORD);
    assign wr_is_ctrl = (wr_word == CTRL_WORD);
    assign rd_word    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_is_pal  = (rd_word < CTRL_WORD);
    assign rd_is_ctrl = (rd_word == CTRL_WORD);

    assign shadow_we = wr_fire & wr_is_pal;
    assign ctrl_we   = wr_fire & wr_is_ctrl & wr_strb[0];
    assign commit    = vsync & commit_pending_q;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], wr_addr[1:0], wr_data};

    // Pick address/data for a write that completes this cycle, from the live bus or the latches
    always_comb begin
        wr_fire = 1'b0;
        wr_addr = awaddr_q;
        wr_data = wdata_q;
        wr_strb = wstrb_q;
        case (wr_state_q)
            W_IDLE: begin
                wr_fire = aw_hs & w_hs;
                wr_addr = S_AXI_AWADDR;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
            end
            W_HAVE_ADDR: begin
                wr_fire = w_hs;
                wr_data = S_AXI_WDATA;
                wr_strb = S_AXI_WSTRB;
            end
            W_HAVE_DATA: begin
                wr_fire = aw_hs;
                wr_addr = S_AXI_AWADDR;
            end
            default: begin
            end
        endcase
    end

    // Write-channel FSM: collect AW and W in any order, then hold B until accepted
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: begin
                if (!wr_fire) begin
                    if (aw_hs) begin
                        awaddr_d   = S_AXI_AWADDR;
                        wr_state_d = W_HAVE_ADDR;
                    end else if (w_hs) begin
                        wdata_d    = S_AXI_WDATA;
                        wstrb_d    = S_AXI_WSTRB;
                        wr_state_d = W_HAVE_DATA;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
            end
        endcase
        if (wr_fire) begin
            wr_state_d = W_RESP;
            bvalid_d   = 1'b1;
            bresp_d    = (wr_is_pal | wr_is_ctrl) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // CTRL register: a shadow write racing a commit re-arms the pending flag
    always_comb begin
        auto_commit_d    = auto_commit_q;
        commit_pending_d = commit_pending_q;
        if (commit) begin
            commit_pending_d = 1'b0;
        end
        if (shadow_we && (auto_commit_q || commit)) begin
            commit_pending_d = 1'b1;
        end
        if (ctrl_we) begin
            auto_commit_d = wr_data[CTRL_AUTO_COMMIT_BIT];
            if (wr_data[CTRL_COMMIT_REQ_BIT]) begin
                commit_pending_d = 1'b1;
            end
        end
    end

    // Read channel: capture decoded data on AR handshake, hold it until RREADY
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            if (rd_is_pal) begin
                rdata_d = C_S_AXI_DATA_WIDTH'(bank_rd_data);
                rresp_d = RESP_OKAY;
            end else if (rd_is_ctrl) begin
                rdata_d                          = '0;
                rdata_d[CTRL_AUTO_COMMIT_BIT]    = auto_commit_q;
                rdata_d[CTRL_COMMIT_PENDING_BIT] = commit_pending_q;
                rresp_d                          = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    // AXI and CTRL state registers; reset abandons any transaction in flight
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q       <= W_IDLE;
            awaddr_q         <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            bvalid_q         <= 1'b0;
            bresp_q          <= RESP_OKAY;
            rvalid_q         <= 1'b0;
            rdata_q          <= '0;
            rresp_q          <= RESP_OKAY;
            auto_commit_q    <= 1'b0;
            commit_pending_q <= 1'b0;
        end else begin
            wr_state_q       <= wr_state_d;
            awaddr_q         <= awaddr_d;
            wdata_q          <= wdata_d;
            wstrb_q          <= wstrb_d;
            bvalid_q         <= bvalid_d;
            bresp_q          <= bresp_d;
            rvalid_q         <= rvalid_d;
            rdata_q          <= rdata_d;
            rresp_q          <= rresp_d;
            auto_commit_q    <= auto_commit_d;
            commit_pending_q <= commit_pending_d;
        end
    end

    palette_bank #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .COLOR_WIDTH (COLOR_WIDTH)
    ) u_bank (
        .clk               (ACLK),
        .rst               (ARESET),
        .i_wr_en           (shadow_we),
        .i_wr_idx          (wr_word[IDX_W-1:0]),
        .i_wr_data         (wr_data[COLOR_WIDTH-1:0]),
        .i_wr_strb         (wr_strb),
        .i_commit          (commit),
        .i_rd_idx          (rd_word[IDX_W-1:0]),
        .o_rd_data         (bank_rd_data),
        .i_pix_valid       (pix_valid),
        .i_pix_index       (pix_index),
        .o_pix_color_valid (pix_color_valid),
        .o_pix_color       (pix_color)
    );

endmodule
`default_nettype wire

// File: tb/tb_axi_color_palette.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_color_palette
// Description : Self-checking bench for axi_color_palette: directed scenarios
//               followed by random bus/pixel traffic against a transaction-
//               level palette model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_color_palette;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        vsync, pix_valid, pix_color_valid;
    logic [3:0]  pix_index;
    logic [23:0] pix_color;

    logic [31:0] shadow_m [N];
    logic [31:0] active_m [N];
    bit          pending_m, auto_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    axi_color_palette dut (
        .ACLK (clk), .ARESET (rst),
        .S_AXI_AWADDR (awaddr), .S_AXI_AWPROT (awprot), .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (awready),
        .S_AXI_WDATA (wdata), .S_AXI_WSTRB (wstrb), .S_AXI_WVALID (wvalid), .S_AXI_WREADY (wready),
        .S_AXI_BRESP (bresp), .S_AXI_BVALID (bvalid), .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr), .S_AXI_ARPROT (arprot), .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready),
        .S_AXI_RDATA (rdata), .S_AXI_RRESP (rresp), .S_AXI_RVALID (rvalid), .S_AXI_RREADY (rready),
        .vsync (vsync), .pix_valid (pix_valid), .pix_index (pix_index),
        .pix_color_valid (pix_color_valid), .pix_color (pix_color)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            shadow_m[i] = 0;
            active_m[i] = 0;
        end
        pending_m = 0;
        auto_m    = 0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r & 32'h00FF_FFFF;
    endfunction

    task automatic model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int w;
        w = int'(a) / 4;
        resp = 2'b00;
        if (w < N) begin
            shadow_m[w] = merge(shadow_m[w], d, s);
            if (auto_m) pending_m = 1;
        end else if (w == N) begin
            if (s[0]) begin
                auto_m = d[1];
                if (d[0]) pending_m = 1;
            end
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
        int w;
        w = int'(a) / 4;
        resp = 2'b00;
        if (w < N)       d = shadow_m[w];
        else if (w == N) d = (pending_m ? 32'd4 : 32'd0) | (auto_m ? 32'd2 : 32'd0);
        else begin
            d    = 0;
            resp = 2'b10;
        end
    endtask

    task automatic model_vsync(input int skip);
        if (pending_m) begin
            for (int i = 0; i < N; i++) if (i != skip) active_m[i] = shadow_m[i];
            pending_m = 0;
        end
    endtask

    // ---------------- bus drivers (called at a negedge) ----------------
    task automatic wr_issue(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, output logic [1:0] exp_resp);
        bit aw_done, w_done, aw_hit, w_hit;
        int t;
        aw_done = 0; w_done = 0; t = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && t < 50) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            #1;
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(negedge clk);
            aw_done = aw_done || aw_hit;
            w_done  = w_done || w_hit;
            t++;
        end
        awvalid = 0;
        wvalid  = 0;
        check("aw_w_handshake", {30'd0, aw_done, w_done}, 32'd3);
        model_write(a, d, s, exp_resp);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        logic [1:0] er;
        wr_issue(a, d, s, aw_dly, w_dly, er);
        check("bvalid_latency", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, {30'd0, er});
        check("awready_blocked", {31'd0, awready}, 32'd0);
        bready = 1;
        @(negedge clk);
        bready = 0;
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic rd_issue(input logic [9:0] a, output logic [31:0] ed, output logic [1:0] er);
        bit hit;
        int t;
        hit = 0; t = 0;
        araddr = a;
        arvalid = 1;
        while (!hit && t < 50) begin
            #1;
            hit = arready;
            @(negedge clk);
            t++;
        end
        arvalid = 0;
        check("ar_handshake", {31'd0, hit}, 32'd1);
        model_read(a, ed, er);
        check("rvalid_latency", {31'd0, rvalid}, 32'd1);
    endtask

    task automatic do_read(input logic [9:0] a);
        logic [31:0] ed;
        logic [1:0]  er;
        rd_issue(a, ed, er);
        check("rdata", rdata, ed);
        check("rresp", {30'd0, rresp}, {30'd0, er});
        rready = 1;
        @(negedge clk);
        rready = 0;
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic step_pix(input bit vs, input bit pv, input int idx);
        logic [31:0] exp;
        vsync     = vs;
        pix_valid = pv;
        pix_index = 4'(idx);
        exp       = active_m[idx];
        if (vs) model_vsync(-1);
        @(negedge clk);
        vsync     = 0;
        pix_valid = 0;
        check("pix_valid", {31'd0, pix_color_valid}, {31'd0, pv});
        if (pv) check("pix_color", {8'd0, pix_color}, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ed, held;
        logic [1:0]  er, bexp;
        rst = 1;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        vsync = 0; pix_valid = 0; pix_index = 0;
        model_reset();
        repeat (3) @(negedge clk);

        // outputs during reset
        check("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
        check("rst_valid", {29'd0, bvalid, rvalid, pix_color_valid}, 32'd0);
        check("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pix", {8'd0, pix_color}, 32'd0);

        rst = 0;
        #1;
        check("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);
        @(negedge clk);

        // AW leads W by two cycles, then read back
        do_write(10'h08, 32'h00FF8040, 4'hF, 0, 2);
        do_read(10'h08);
        // single byte lane, top byte never stored
        do_write(10'h00, 32'h11223344, 4'h2, 0, 0);
        do_read(10'h00);
        // W before AW
        do_write(10'h04, 32'hDEADBEEF, 4'hF, 3, 0);
        do_read(10'h04);

        // commit via CTRL bit0 on vsync
        do_write(10'h14, 32'h00123456, 4'hF, 0, 0);
        step_pix(0, 1, 5);
        do_write(10'h40, 32'h1, 4'h1, 0, 0);
        do_read(10'h40);
        step_pix(1, 1, 5);
        step_pix(0, 1, 5);
        do_read(10'h40);

        // shadow write coinciding with a commit vsync under auto_commit
        do_write(10'h40, 32'h2, 4'h1, 0, 0);
        do_write(10'h1C, 32'h00ABCDEF, 4'hF, 1, 0);
        awaddr = 10'h0C; wdata = 32'h00A1B2C3; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; vsync = 1; pix_valid = 1; pix_index = 4'd3;
        #1;
        check("coincide_ready", {30'd0, awready, wready}, 32'd3);
        ed = active_m[3];
        model_vsync(3);
        shadow_m[3] = 32'h00A1B2C3;
        pending_m = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0; vsync = 0; pix_valid = 0;
        check("coincide_pix", {8'd0, pix_color}, ed);
        check("coincide_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1;
        @(negedge clk);
        bready = 0;
        step_pix(0, 1, 3);
        step_pix(0, 1, 7);
        do_read(10'h40);
        step_pix(1, 0, 0);
        step_pix(0, 1, 3);

        // unmapped offset just past CTRL
        do_write(10'h44, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_read(10'h44);
        do_read(10'h40);
        do_read(10'h0C);

        // backpressure on B and R, then reset mid-transaction
        wr_issue(10'h18, 32'h00C0FFEE, 4'hF, 0, 0, bexp);
        rd_issue(10'h08, ed, er);
        for (int i = 0; i < 10; i++) begin
            check("hold_bvalid", {31'd0, bvalid}, 32'd1);
            check("hold_bresp", {30'd0, bresp}, {30'd0, bexp});
            check("hold_rvalid", {31'd0, rvalid}, 32'd1);
            check("hold_rdata", rdata, ed);
            check("hold_ready", {29'd0, awready, wready, arready}, 32'd0);
            @(negedge clk);
        end
        held = rdata;
        rst = 1;
        #1;
        check("midrst_outputs", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_resp", {28'd0, bresp, rresp}, 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_resp", {30'd0, bvalid, rvalid}, 32'd0);
        end
        do_read(10'h08);
        step_pix(0, 1, 5);

        // random traffic
        for (int it = 0; it < 120; it++) begin
            int op, w;
            op = int'($urandom_range(0, 4));
            case (op)
                0, 1: begin
                    w = int'($urandom_range(0, N - 1));
                    do_write(10'(w * 4), $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                end
                2: begin
                    w = int'($urandom_range(0, N + 2));
                    do_read(10'(w * 4));
                end
                3: step_pix($urandom_range(0, 2) == 0, 1'b1, int'($urandom_range(0, N - 1)));
                default: do_write(10'h40, {30'd0, 2'($urandom_range(0, 3))}, 4'hF, 0, 0);
            endcase
        end
        step_pix(1, 0, 0);
        for (int i = 0; i < N; i++) step_pix(0, 1, i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/axi_color_palette.md
AXI_COLOR_PALETTE -- requirements
Module: axi_color_palette

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, number of palette entries (power of 2, 2..256).
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (fixed at 32).
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 10, byte address width (>= clog2(NUM_ENTRIES*4)+1).
REQ-004 SHALL have parameter COLOR_WIDTH, default 24, stored bits per entry (RGB888); upper data bits read 0.
REQ-005 ACLK  input  1  sole clock, rising edge.
REQ-006 ARESET  input  1  asynchronous, active-high reset.
REQ-007 S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY  standard AXI4-Lite write channels, widths per parameters.
REQ-008 S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite read channels.
REQ-009 vsync  input  1  one-cycle frame-boundary pulse.
REQ-010 pix_valid  input  1; pix_index  input  clog2(NUM_ENTRIES)  pixel lookup request.
REQ-011 pix_color_valid  output  1; pix_color  output  COLOR_WIDTH  lookup result.

Function
REQ-012 Map: word i (byte offset 4*i, i < NUM_ENTRIES) = shadow entry i; offset 4*NUM_ENTRIES = CTRL (bit0 commit_req, bit1 auto_commit, bit2 commit_pending RO); other offsets unmapped.
REQ-013 Write: AW and W SHALL be accepted independently, in either order or together; each READY deasserts after its handshake until B completes; one write outstanding.
REQ-014 Write executes the cycle both AW and W are held; byte lanes applied per WSTRB; BVALID asserts the next cycle, holds until BREADY.
REQ-015 Unmapped write: no state change, BRESP=SLVERR (2'b10); mapped: OKAY.
REQ-016 Read: ARREADY high when no RVALID pending; RVALID one cycle after AR handshake, RDATA/RRESP held stable until RREADY.
REQ-017 Palette reads return the shadow bank; unmapped read returns 0 with SLVERR.
REQ-018 Read and write of same entry in the same cycle: read returns pre-write value.
REQ-019 Writing CTRL bit0=1 sets commit_pending; any shadow write with auto_commit=1 also sets it.
REQ-020 On vsync with commit_pending=1: entire shadow copied to active bank that cycle, commit_pending cleared.
REQ-021 Shadow write coinciding with a commit vsync: write lands in shadow only, is excluded from the copy, and commit_pending stays/becomes 1.
REQ-022 Pixel lookup: pix_color = active[pix_index], pix_color_valid = pix_valid, both registered, latency exactly 1 cycle, one lookup per cycle.
REQ-023 Lookup in the commit cycle SHALL return pre-commit active value; the following cycle sees new data.

Reset
REQ-024 On ARESET all READY/VALID outputs 0, BRESP/RRESP/RDATA 0, pix_color 0, pix_color_valid 0, CTRL 0, both banks 0.
REQ-025 ARESET mid-transaction SHALL abandon it; no B/R response issued after release.
REQ-026 First AXI handshake allowed on the first ACLK edge after ARESET deasserts.

Structure
REQ-027 Package color_palette_pkg SHALL hold AXI resp constants (OKAY, SLVERR), CTRL bit indices, and the write-FSM state typedef (W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP).
REQ-028 One sub-module, palette_bank (shadow+active storage, copy, lookup port), SHALL be instantiated; AXI FSMs live in the top.

Verification
REQ-029 AW then W two cycles later to offset 0x08, data 0x00FF8040, WSTRB 0xF -> BRESP OKAY, read 0x08 returns 0x00FF8040.
REQ-030 Write 0x11223344 with WSTRB 0x2 to entry 0 holding 0 -> reads 0x00003300 (bit 31..24 always 0).
REQ-031 Write entry 5 = 0x123456, pix_index 5 before vsync -> pix_color old value; write CTRL 0x1, vsync pulse, next-cycle lookup -> 0x123456, commit_pending 0.
REQ-032 Write to entry 3 in same cycle as commit vsync, auto_commit=1 -> active unchanged for entry 3, commit_pending 1; next vsync -> active updated.
REQ-033 Write/read offset 4*NUM_ENTRIES+4 -> SLVERR, RDATA 0, no bank change.
REQ-034 BREADY/RREADY held low 10 cycles -> BVALID/RVALID and data stable, no new AW/AR accepted; ARESET pulsed mid-burst -> all outputs 0, no stale response.
